// File: rtl/tlc_pkg.sv
// Shared intersection-controller definitions: lamp patterns, controller states,
// monitor phase codes and fault codes.
package tlc_pkg;

   localparam int unsigned LAMP_W  = 7;
   localparam int unsigned PHASE_W = 3;
   localparam int unsigned DWELL_W = 4;
   localparam int unsigned CODE_W  = 3;
   localparam int unsigned CNT_W   = 8;

   localparam logic [PHASE_W-1:0] PH_MG   = 3'd0;
   localparam logic [PHASE_W-1:0] PH_MY   = 3'd1;
   localparam logic [PHASE_W-1:0] PH_WK   = 3'd2;
   localparam logic [PHASE_W-1:0] PH_SG   = 3'd3;
   localparam logic [PHASE_W-1:0] PH_SY   = 3'd4;
   localparam logic [PHASE_W-1:0] PH_NONE = 3'd7;

   localparam logic [CODE_W-1:0] FC_NONE        = 3'd0;
   localparam logic [CODE_W-1:0] FC_INVALID     = 3'd1;
   localparam logic [CODE_W-1:0] FC_ILLEGAL     = 3'd2;
   localparam logic [CODE_W-1:0] FC_GREEN_SHORT = 3'd3;
   localparam logic [CODE_W-1:0] FC_GREEN_LONG  = 3'd4;
   localparam logic [CODE_W-1:0] FC_YELLOW      = 3'd5;
   localparam logic [CODE_W-1:0] FC_WALK        = 3'd6;

   // Controller sequencing states, mirrored by the monitor phase codes.
   typedef enum logic [2:0] {
      CTL_MAIN_GO   = 3'd0,
      CTL_MAIN_WARN = 3'd1,
      CTL_WALK      = 3'd2,
      CTL_SIDE_GO   = 3'd3,
      CTL_SIDE_WARN = 3'd4
   } ctl_state_e;

   typedef enum logic [1:0] {
      MON_UNSYNCED = 2'd0,
      MON_FIRST    = 2'd1,
      MON_CHECKED  = 2'd2
   } mon_state_e;

   typedef struct packed {
      logic main_green;
      logic main_yellow;
      logic main_red;
      logic side_green;
      logic side_yellow;
      logic side_red;
      logic walk_lamp;
   } lamp_vec_t;

   localparam lamp_vec_t LAMPS_MG = LAMP_W'(7'b100_0010);
   localparam lamp_vec_t LAMPS_MY = LAMP_W'(7'b010_0010);
   localparam lamp_vec_t LAMPS_WK = LAMP_W'(7'b001_0011);
   localparam lamp_vec_t LAMPS_SG = LAMP_W'(7'b001_1000);
   localparam lamp_vec_t LAMPS_SY = LAMP_W'(7'b001_0100);

   function automatic logic legal_transition(input logic [PHASE_W-1:0] from_ph,
                                             input logic [PHASE_W-1:0] to_ph);
      logic ok;
      ok = 1'b0;
      case (from_ph)
         PH_MG:   ok = (to_ph == PH_MY);
         PH_MY:   ok = (to_ph == PH_WK) || (to_ph == PH_SG);
         PH_WK:   ok = (to_ph == PH_SG);
         PH_SG:   ok = (to_ph == PH_SY);
         PH_SY:   ok = (to_ph == PH_MG);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic is_green(input logic [PHASE_W-1:0] ph);
      return (ph == PH_MG) || (ph == PH_SG);
   endfunction

   function automatic logic is_yellow(input logic [PHASE_W-1:0] ph);
      return (ph == PH_MY) || (ph == PH_SY);
   endfunction

endpackage

// File: rtl/phase_decoder.sv
// Combinational decode of the seven observed lamp drives into a phase code;
// anything other than an exact legal pattern decodes as PH_NONE.
module phase_decoder
   import tlc_pkg::*;
(
   input  logic               main_green,
   input  logic               main_yellow,
   input  logic               main_red,
   input  logic               side_green,
   input  logic               side_yellow,
   input  logic               side_red,
   input  logic               walk_lamp,
   output logic [PHASE_W-1:0] phase_c
);

   lamp_vec_t lamps_c;

   assign lamps_c = {main_green, main_yellow, main_red,
                     side_green, side_yellow, side_red, walk_lamp};

   always_comb begin
      phase_c = PH_NONE;
      case (lamps_c)
         LAMPS_MG: phase_c = PH_MG;
         LAMPS_MY: phase_c = PH_MY;
         LAMPS_WK: phase_c = PH_WK;
         LAMPS_SG: phase_c = PH_SG;
         LAMPS_SY: phase_c = PH_SY;
         default:  phase_c = PH_NONE;
      endcase
   end

endmodule

// File: rtl/lamp_monitor.sv
// Watches the intersection lamp drives, tracks phase and dwell, and captures the
// first sequencing/timing violation as a sticky fault code.
module lamp_monitor
   import tlc_pkg::*;
#(
   parameter int unsigned GREEN_MIN    = 6,
   parameter int unsigned GREEN_MAX    = 12,
   parameter int unsigned YELLOW_TICKS = 2,
   parameter int unsigned WALK_TICKS   = 3
) (
   input  logic                new_clk,
   input  logic                rst,
   input  logic                main_green,
   input  logic                main_yellow,
   input  logic                main_red,
   input  logic                side_green,
   input  logic                side_yellow,
   input  logic                side_red,
   input  logic                walk_lamp,
   input  logic                clr_fault,
   output logic [PHASE_W-1:0]  phase,
   output logic [DWELL_W-1:0]  dwell,
   output logic                fault,
   output logic [CODE_W-1:0]   fault_code,
   output logic [CNT_W-1:0]    cycle_count,
   output logic                cycle_done
);

   localparam logic [DWELL_W-1:0] G_MIN_D  = DWELL_W'(GREEN_MIN);
   localparam logic [DWELL_W-1:0] G_MAX_D  = DWELL_W'(GREEN_MAX);
   localparam logic [DWELL_W-1:0] Y_D      = DWELL_W'(YELLOW_TICKS);
   localparam logic [DWELL_W-1:0] W_D      = DWELL_W'(WALK_TICKS);
   localparam logic [DWELL_W-1:0] DWELL_SAT = '1;

   logic [PHASE_W-1:0] dec_phase_c;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               fault_q, fault_d;
   logic [CODE_W-1:0]  fault_code_q, fault_code_d;
   logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
   logic               cycle_done_q, cycle_done_d;
   mon_state_e         state_q, state_d;
   logic               trans_chk_c;
   logic               dur_chk_c;
   logic               changed_c;
   logic               cycle_hit_c;
   logic [CODE_W-1:0]  det_code_c;

   phase_decoder u_phase_decoder (
      .main_green  (main_green),
      .main_yellow (main_yellow),
      .main_red    (main_red),
      .side_green  (side_green),
      .side_yellow (side_yellow),
      .side_red    (side_red),
      .walk_lamp   (walk_lamp),
      .phase_c     (dec_phase_c)
   );

   assign changed_c = (dec_phase_c != phase_q);

   // Sync tracker: the first phase after (re)sync is exempt from duration checks.
   always_ff @(posedge new_clk) begin
      if (rst) state_q <= MON_UNSYNCED;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (dec_phase_c == PH_NONE) begin
         state_d = MON_UNSYNCED;
      end else begin
         case (state_q)
            MON_UNSYNCED: state_d = MON_FIRST;
            MON_FIRST:    if (changed_c) state_d = MON_CHECKED;
            MON_CHECKED:  state_d = MON_CHECKED;
            default:      state_d = MON_UNSYNCED;
         endcase
      end
   end

   always_comb begin
      trans_chk_c = 1'b0;
      dur_chk_c   = 1'b0;
      case (state_q)
         MON_FIRST:   trans_chk_c = 1'b1;
         MON_CHECKED: begin
            trans_chk_c = 1'b1;
            dur_chk_c   = 1'b1;
         end
         default: ;
      endcase
   end

   // Violation detect; chain order yields the lowest applicable code.
   always_comb begin
      det_code_c = FC_NONE;
      if (dec_phase_c == PH_NONE) begin
         det_code_c = FC_INVALID;
      end else if (trans_chk_c && changed_c && !legal_transition(phase_q, dec_phase_c)) begin
         det_code_c = FC_ILLEGAL;
      end else if (dur_chk_c && changed_c) begin
         if (is_green(phase_q) && (dwell_q < G_MIN_D))       det_code_c = FC_GREEN_SHORT;
         else if (is_yellow(phase_q) && (dwell_q != Y_D))    det_code_c = FC_YELLOW;
         else if ((phase_q == PH_WK) && (dwell_q != W_D))    det_code_c = FC_WALK;
      end else if (dur_chk_c) begin
         if (is_green(phase_q) && (dwell_q == G_MAX_D))      det_code_c = FC_GREEN_LONG;
         else if (is_yellow(phase_q) && (dwell_q >= Y_D))    det_code_c = FC_YELLOW;
         else if ((phase_q == PH_WK) && (dwell_q >= W_D))    det_code_c = FC_WALK;
      end
   end

   assign cycle_hit_c = trans_chk_c && (phase_q == PH_SY) && (dec_phase_c == PH_MG);

   always_comb begin
      phase_d       = dec_phase_c;
      dwell_d       = dwell_q;
      fault_d       = fault_q;
      fault_code_d  = fault_code_q;
      cycle_count_d = cycle_count_q;
      cycle_done_d  = 1'b0;
      if (changed_c)                dwell_d = DWELL_W'(1);
      else if (dwell_q != DWELL_SAT) dwell_d = dwell_q + DWELL_W'(1);
      if (cycle_hit_c) begin
         cycle_count_d = cycle_count_q + CNT_W'(1);
         cycle_done_d  = 1'b1;
      end
      // A fresh detection beats a simultaneous clear.
      if ((det_code_c != FC_NONE) && (!fault_q || clr_fault)) begin
         fault_d      = 1'b1;
         fault_code_d = det_code_c;
      end else if (clr_fault) begin
         fault_d      = 1'b0;
         fault_code_d = FC_NONE;
      end
   end

   always_ff @(posedge new_clk) begin
      if (rst) begin
         phase_q       <= PH_NONE;
         dwell_q       <= '0;
         fault_q       <= 1'b0;
         fault_code_q  <= FC_NONE;
         cycle_count_q <= '0;
         cycle_done_q  <= 1'b0;
      end else begin
         phase_q       <= phase_d;
         dwell_q       <= dwell_d;
         fault_q       <= fault_d;
         fault_code_q  <= fault_code_d;
         cycle_count_q <= cycle_count_d;
         cycle_done_q  <= cycle_done_d;
      end
   end

   assign phase       = phase_q;
   assign dwell       = dwell_q;
   assign fault       = fault_q;
   assign fault_code  = fault_code_q;
   assign cycle_count = cycle_count_q;
   assign cycle_done  = cycle_done_q;

endmodule

// File: tb/tb_lamp_monitor.sv
// Bench for lamp_monitor: directed scenarios plus random lamp sequences, every
// tick compared against a history-based reference model.
module tb_lamp_monitor;

   localparam int GMIN = 6;
   localparam int GMAX = 12;
   localparam int YT   = 2;
   localparam int WT   = 3;

   localparam int MG = 0, MY = 1, WK = 2, SG = 3, SY = 4, NONE = 7;

   logic       new_clk = 1'b0;
   logic       rst = 1'b1;
   logic       mg = 1'b0, my = 1'b0, mr = 1'b0, sg = 1'b0, sy = 1'b0, sr = 1'b0, wk = 1'b0;
   logic       clr_fault = 1'b0;
   logic [2:0] phase;
   logic [3:0] dwell;
   logic       fault;
   logic [2:0] fault_code;
   logic [7:0] cycle_count;
   logic       cycle_done;

   always #5 new_clk = ~new_clk;

   lamp_monitor #(
      .GREEN_MIN    (GMIN),
      .GREEN_MAX    (GMAX),
      .YELLOW_TICKS (YT),
      .WALK_TICKS   (WT)
   ) dut (
      .new_clk     (new_clk),
      .rst         (rst),
      .main_green  (mg),
      .main_yellow (my),
      .main_red    (mr),
      .side_green  (sg),
      .side_yellow (sy),
      .side_red    (sr),
      .walk_lamp   (wk),
      .clr_fault   (clr_fault),
      .phase       (phase),
      .dwell       (dwell),
      .fault       (fault),
      .fault_code  (fault_code),
      .cycle_count (cycle_count),
      .cycle_done  (cycle_done)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Lamp order {mg, my, mr, sg, sy, sr, wk}
   function automatic logic [6:0] lamp_of(input int ph);
      case (ph)
         MG:      return 7'b100_0010;
         MY:      return 7'b010_0010;
         WK:      return 7'b001_0011;
         SG:      return 7'b001_1000;
         SY:      return 7'b001_0100;
         default: return 7'b100_1000;
      endcase
   endfunction

   function automatic int ph_of(input logic [6:0] l);
      for (int p = 0; p < 5; p++) if (l == lamp_of(p)) return p;
      return NONE;
   endfunction

   function automatic bit legal(input int a, input int b);
      return (a == MG && b == MY) || (a == MY && (b == WK || b == SG)) ||
             (a == WK && b == SG) || (a == SG && b == SY) || (a == SY && b == MG);
   endfunction

   function automatic int lower(input int cur, input int c);
      return (cur == 0 || c < cur) ? c : cur;
   endfunction

   // Reference model: phase history since last reset/invalid tick.
   int hist[$];
   int m_ph = NONE, m_run = 0, m_fault = 0, m_code = 0, m_cnt = 0, m_done = 0;

   task automatic model_step(input logic [6:0] l, input logic c, input logic r);
      int p, prev, run, code;
      bit first, grn, yel;
      if (r) begin
         hist.delete();
         m_ph = NONE; m_run = 0; m_fault = 0; m_code = 0; m_cnt = 0; m_done = 0;
         return;
      end
      p = ph_of(l);
      code = 0;
      m_done = 0;
      if (p == NONE) begin
         code = 1;
         hist.delete();
      end else begin
         if (hist.size() > 0) begin
            prev = hist[hist.size()-1];
            run = 0;
            for (int i = hist.size()-1; i >= 0 && hist[i] == prev; i--) run++;
            first = (run == hist.size());
            grn = (prev == MG || prev == SG);
            yel = (prev == MY || prev == SY);
            if (p != prev) begin
               if (!legal(prev, p)) code = lower(code, 2);
               if (!first) begin
                  if (grn && run < GMIN)      code = lower(code, 3);
                  if (yel && run != YT)       code = lower(code, 5);
                  if (prev == WK && run != WT) code = lower(code, 6);
               end
               if (prev == SY && p == MG) begin
                  m_cnt = (m_cnt + 1) % 256;
                  m_done = 1;
               end
            end else if (!first) begin
               if (grn && run + 1 == GMAX + 1) code = lower(code, 4);
               if (yel && run + 1 > YT)        code = lower(code, 5);
               if (prev == WK && run + 1 > WT) code = lower(code, 6);
            end
         end
         hist.push_back(p);
      end
      if (p == m_ph) m_run++;
      else begin m_ph = p; m_run = 1; end
      if (code != 0 && (m_fault == 0 || c)) begin
         m_fault = 1; m_code = code;
      end else if (c) begin
         m_fault = 0; m_code = 0;
      end
   endtask

   task automatic tick(input logic [6:0] l, input logic c, input logic r);
      {mg, my, mr, sg, sy, sr, wk} = l;
      clr_fault = c;
      rst = r;
      @(posedge new_clk);
      #1;
      model_step(l, c, r);
      chk("phase", phase, m_ph);
      chk("dwell", dwell, (m_run > 15) ? 15 : m_run);
      chk("fault", fault, m_fault);
      chk("fault_code", fault_code, m_code);
      chk("cycle_count", cycle_count, m_cnt);
      chk("cycle_done", cycle_done, m_done);
   endtask

   task automatic seg(input int ph, input int n);
      repeat (n) tick(lamp_of(ph), 1'b0, 1'b0);
   endtask

   function automatic int succ(input int g);
      case (g)
         MG:      return MY;
         MY:      return ($urandom_range(0, 2) == 0) ? WK : SG;
         WK:      return SG;
         SG:      return SY;
         default: return MG;
      endcase
   endfunction

   function automatic int dur(input int g);
      if (g == MG || g == SG) return $urandom_range(GMIN - 1, GMAX + 1);
      if (g == WK)            return $urandom_range(WT - 1, WT + 1);
      return $urandom_range(YT - 1, YT + 1);
   endfunction

   initial begin
      logic [6:0] bad;
      int g, x;

      tick(lamp_of(MG), 1'b0, 1'b1);
      tick(lamp_of(MG), 1'b1, 1'b1);
      chk("rst_phase", phase, 7);
      chk("rst_dwell", dwell, 0);
      chk("rst_fault", fault, 0);

      // Nominal cycle
      for (int i = 1; i <= 12; i++) begin
         tick(lamp_of(MG), 1'b0, 1'b0);
         chk("nom_dwell", dwell, i);
      end
      seg(MY, 2); seg(SG, 6); seg(SY, 2); seg(MG, 1);
      chk("nom_fault", fault, 0);
      chk("nom_cnt", cycle_count, 1);
      chk("nom_done", cycle_done, 1);
      seg(MG, 1);
      chk("nom_done_off", cycle_done, 0);

      // Walk path, then a short walk
      seg(MG, 7); seg(MY, 2); seg(WK, 3); seg(SG, 9); seg(SY, 2); seg(MG, 1);
      chk("walk_fault", fault, 0);
      chk("walk_cnt", cycle_count, 2);
      seg(MG, 8); seg(MY, 2); seg(WK, 2); seg(SG, 1);
      chk("walk_short", fault_code, 6);

      // Conflict, then unchecked resync phase
      tick(lamp_of(MG), 1'b0, 1'b1);
      seg(MG, 3);
      bad = 7'b100_1000;
      tick(bad, 1'b0, 1'b0);
      chk("conf_code", fault_code, 1);
      chk("conf_phase", phase, 7);
      tick(lamp_of(SG), 1'b1, 1'b0);
      chk("conf_clr", fault, 0);
      seg(SG, 1); seg(SY, 2); seg(MG, 1);
      chk("resync_fault", fault, 0);
      chk("resync_cnt", cycle_count, 1);

      // Illegal MG->SG; later short yellow must not overwrite
      seg(MG, 5); seg(SG, 1);
      chk("illegal", fault_code, 2);
      seg(SG, 5); seg(SY, 1); seg(MG, 1);
      chk("illegal_sticky", fault_code, 2);

      // Long green, short green, clear racing a short-yellow exit
      tick(lamp_of(MG), 1'b0, 1'b1);
      seg(MG, 3); seg(MY, 2); seg(SG, 6); seg(SY, 2); seg(MG, 12);
      chk("long_none", fault, 0);
      seg(MG, 1);
      chk("long_code", fault_code, 4);
      tick(lamp_of(MG), 1'b1, 1'b0);
      chk("long_clr", fault, 0);
      seg(MY, 2); seg(SG, 5); seg(SY, 1);
      chk("short_green", fault_code, 3);
      tick(lamp_of(MG), 1'b1, 1'b0);
      chk("clr_race_f", fault, 1);
      chk("clr_race_c", fault_code, 5);

      // Reset mid side-green
      seg(MG, 6); seg(MY, 2); seg(SG, 3);
      tick(lamp_of(SG), 1'b0, 1'b1);
      chk("midrst_phase", phase, 7);
      chk("midrst_dwell", dwell, 0);
      chk("midrst_fault", fault, 0);
      chk("midrst_code", fault_code, 0);
      chk("midrst_cnt", cycle_count, 0);
      chk("midrst_done", cycle_done, 0);

      // cycle_count wrap
      seg(MG, 6);
      for (int k = 0; k < 256; k++) begin
         seg(MY, 2); seg(SG, 6); seg(SY, 2); seg(MG, 6);
      end
      chk("wrap_cnt", cycle_count, 0);
      chk("wrap_fault", fault, 0);

      // Random sequences
      tick(lamp_of(MG), 1'b0, 1'b1);
      g = MG;
      for (int t = 0; t < 3000; t++) begin
         int n;
         n = dur(g);
         for (int k = 0; k < n; k++)
            tick(lamp_of(g), ($urandom_range(0, 9) == 0), ($urandom_range(0, 399) == 0));
         x = $urandom_range(0, 29);
         if (x == 0) begin
            do bad = 7'($urandom); while (ph_of(bad) != NONE);
            tick(bad, ($urandom_range(0, 9) == 0), 1'b0);
            g = $urandom_range(0, 4);
         end else if (x < 3) begin
            g = $urandom_range(0, 4);
         end else begin
            g = succ(g);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lamp_monitor.md
LAMP_MONITOR -- requirements
Module: lamp_monitor

Interface
REQ-001 Parameter GREEN_MIN, default 6, SHALL be the minimum ticks a green phase (main or side) must last.
REQ-002 Parameter GREEN_MAX, default 12, SHALL be the maximum ticks a green phase may last; legal range GREEN_MIN..14.
REQ-003 Parameter YELLOW_TICKS, default 2, SHALL be the exact required yellow duration in ticks.
REQ-004 Parameter WALK_TICKS, default 3, SHALL be the exact required walk duration in ticks.
REQ-005 new_clk  in  1  one tick per second; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 main_green, main_yellow, main_red, side_green, side_yellow, side_red, walk_lamp  in  1 each  observed lamp drives from the intersection controller.
REQ-008 clr_fault  in  1  synchronous clear of the sticky fault.
REQ-009 phase  out  3  registered decoded phase: 0 MG, 1 MY, 2 WK, 3 SG, 4 SY, 7 NONE/INVALID.
REQ-010 dwell  out  4  ticks spent in current phase, saturating at 15.
REQ-011 fault  out  1  sticky fault flag.
REQ-012 fault_code  out  3  code of first captured fault.
REQ-013 cycle_count  out  8  completed SY->MG cycles, wraps 255->0.
REQ-014 cycle_done  out  1  one-tick pulse on each SY->MG transition.

Function
REQ-015 Each tick the lamp vector SHALL be decoded: MG = main_green & side_red only; MY = main_yellow & side_red only; WK = main_red & side_red & walk_lamp only; SG = main_red & side_green only; SY = main_red & side_yellow only; any other combination = INVALID.
REQ-016 Legal transitions SHALL be exactly MG->MY, MY->WK, MY->SG, WK->SG, SG->SY, SY->MG; same phase = stay.
REQ-017 On a phase change, phase SHALL update and dwell SHALL load 1 on that tick; while unchanged, dwell SHALL increment, saturating at 15.
REQ-018 Monitor SHALL start UNSYNCED; first valid decoded phase SETS synced; the duration of that first phase is not checked, transitions out of it are.
REQ-019 Fault codes: 1 INVALID combination; 2 illegal transition; 3 green left with dwell < GREEN_MIN; 4 green still present when dwell would reach GREEN_MAX+1; 5 yellow left with dwell != YELLOW_TICKS or dwell exceeds YELLOW_TICKS; 6 walk same rule with WALK_TICKS.
REQ-020 Fault detection SHALL occur on the tick the condition is seen; fault and fault_code are registered, visible the following tick.
REQ-021 Multiple simultaneous conditions SHALL record the lowest code.
REQ-022 fault SHALL be sticky: later faults do not overwrite fault_code until cleared.
REQ-023 clr_fault SHALL zero fault and fault_code; a fault detected in the same tick as clr_fault SHALL win and be captured.
REQ-024 INVALID SHALL set phase = 7, clear synced and force resync per REQ-018.
REQ-025 cycle_count SHALL increment and cycle_done pulse only on legal SY->MG with synced set.

Reset
REQ-026 On rst: phase = 7, dwell = 0, fault = 0, fault_code = 0, cycle_count = 0, cycle_done = 0, synced = 0; rst overrides clr_fault and all detection.
REQ-027 rst asserted mid-phase SHALL discard dwell history; the phase seen after release is unchecked in duration.

Structure
REQ-028 Phase encodings and fault codes SHALL live in shared package tlc_pkg alongside the controller state constants.
REQ-029 Lamp decoding SHALL be a combinational sub-module phase_decoder (7 lamp inputs -> 3-bit phase); checking, counters and fault capture stay in lamp_monitor.

Verification
REQ-030 Nominal: MG 12, MY 2, SG 6, SY 2, MG -> fault = 0, cycle_count = 1, one cycle_done pulse, dwell sequence 1..12 in first MG.
REQ-031 Walk path: MG 9, MY 2, WK 3, SG 9, SY 2 -> no fault; WK 2 ticks instead -> fault_code = 6.
REQ-032 Conflict: main_green and side_green both high for 1 tick -> fault_code = 1, phase = 7, next valid phase unchecked in duration.
REQ-033 Illegal MG->SG directly after synced -> fault_code = 2; subsequent short yellow does not overwrite code.
REQ-034 Green held 13 ticks -> fault_code = 4 flagged on tick 13; green of 5 ticks -> fault_code = 3.
REQ-035 clr_fault pulse coinciding with a short-yellow exit -> fault = 1, fault_code = 5; rst mid-SG -> all outputs at reset values next tick.
